// File: rtl/frame_draw_scheduler_pkg.sv
// Shared types and constants for the frame draw scheduler: screen geometry,
// scheduler states, plot pipeline payload and palette constants.
package frame_draw_scheduler_pkg;

  localparam int unsigned H_RES = 320;
  localparam int unsigned V_RES = 240;
  localparam int unsigned XW    = 9;
  localparam int unsigned YW    = 8;
  localparam int unsigned YIW   = 9;
  localparam int unsigned CW    = 3;

  localparam logic [CW-1:0] BLACK = 3'b000;
  localparam logic [CW-1:0] WHITE = 3'b111;
  localparam logic [CW-1:0] GRASS = 3'b010;
  localparam logic [CW-1:0] HELI  = 3'b110;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BG_SCAN  = 2'd1,
    BG_FLUSH = 2'd2,
    SPRITE   = 2'd3
  } state_t;

  // One slot of the plot delay stage
  typedef struct packed {
    logic          valid;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pix_t;

  function automatic logic on_screen(input logic [XW-1:0] x, input logic [YIW-1:0] y);
    return (x < XW'(H_RES)) && (y < YIW'(V_RES));
  endfunction

endpackage

// File: rtl/frame_draw_scheduler_raster_counter.sv
// Raster x/y scan counter with wrap, synchronous clear/enable and a
// combinational flag marking the final pixel of the frame.
module raster_counter
  import frame_draw_scheduler_pkg::*;
(
  input  logic           clock,
  input  logic           resetn,
  input  logic           i_clr,
  input  logic           i_en,
  output logic [XW-1:0]  o_x,
  output logic [YIW-1:0] o_y,
  output logic           o_last_c
);

  logic [XW-1:0]  r_x;
  logic [YIW-1:0] r_y;
  logic           w_x_end;
  logic           w_y_end;

  assign w_x_end  = (r_x == XW'(H_RES - 1));
  assign w_y_end  = (r_y == YIW'(V_RES - 1));
  assign o_last_c = w_x_end && w_y_end;
  assign o_x      = r_x;
  assign o_y      = r_y;

  always_ff @(posedge clock) begin
    if (!resetn || i_clr) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_en) begin
      if (w_x_end) begin
        r_x <= '0;
        r_y <= w_y_end ? '0 : r_y + YIW'(1);
      end else begin
        r_x <= r_x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/frame_draw_scheduler.sv
// Owns the VGA adapter pixel port: raster-scans the background lookup on
// request and grants the port to a sprite drawer between repaints.
module frame_draw_scheduler
  import frame_draw_scheduler_pkg::*;
(
  input  logic           clock,
  input  logic           resetn,
  input  logic           start,
  output logic [XW-1:0]  bg_x,
  output logic [YIW-1:0] bg_y,
  input  logic [CW-1:0]  bg_colour,
  input  logic           spr_req,
  input  logic [XW-1:0]  spr_x,
  input  logic [YIW-1:0] spr_y,
  input  logic [CW-1:0]  spr_colour,
  input  logic           spr_last,
  output logic           spr_gnt,
  output logic [XW-1:0]  vga_x,
  output logic [YW-1:0]  vga_y,
  output logic [CW-1:0]  vga_colour,
  output logic           vga_plot,
  output logic           busy,
  output logic           frame_done
);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_pending;
  logic          w_pending_nxt;
  logic          r_gnt;
  logic          r_busy;
  logic          r_done;
  logic          w_cnt_clr;
  logic          w_cnt_en;
  logic          w_scan_last;
  logic          w_accept;
  logic          w_pend_any;
  pix_t          r_pix;
  logic [CW-1:0] r_spr_colour;
  logic          r_src_spr;

  raster_counter u_raster (
    .clock    (clock),
    .resetn   (resetn),
    .i_clr    (w_cnt_clr),
    .i_en     (w_cnt_en),
    .o_x      (bg_x),
    .o_y      (bg_y),
    .o_last_c (w_scan_last)
  );

  assign w_accept   = r_gnt && spr_req;
  assign w_pend_any = r_pending || start;

  // Next-state: a start seen while busy is queued and wins over sprites
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending || (start && (r_state != IDLE));
    w_cnt_clr     = 1'b0;
    w_cnt_en      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = BG_SCAN;
          w_cnt_clr   = 1'b1;
        end else if (spr_req) begin
          w_state_nxt = SPRITE;
        end
      end
      BG_SCAN: begin
        w_cnt_en = 1'b1;
        if (w_scan_last) begin
          w_state_nxt = BG_FLUSH;
        end
      end
      BG_FLUSH: begin
        if (w_pend_any) begin
          w_state_nxt   = BG_SCAN;
          w_cnt_clr     = 1'b1;
          w_pending_nxt = 1'b0;
        end else if (spr_req) begin
          w_state_nxt = SPRITE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SPRITE: begin
        if (w_accept && spr_last) begin
          if (w_pend_any) begin
            w_state_nxt   = BG_SCAN;
            w_cnt_clr     = 1'b1;
            w_pending_nxt = 1'b0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_pending <= 1'b0;
      r_gnt     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_gnt     <= (w_state_nxt == SPRITE);
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= (r_state == BG_FLUSH);
    end
  end

  // Plot delay stage: background coords line up with the lookup latency
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_pix        <= '0;
      r_spr_colour <= '0;
      r_src_spr    <= 1'b0;
    end else begin
      r_src_spr <= (r_state == SPRITE);
      if (r_state == BG_SCAN) begin
        r_pix <= '{valid: 1'b1, x: bg_x, y: bg_y[YW-1:0]};
      end else if (w_accept) begin
        r_pix        <= '{valid: on_screen(spr_x, spr_y), x: spr_x, y: spr_y[YW-1:0]};
        r_spr_colour <= spr_colour;
      end else begin
        r_pix.valid <= 1'b0;
      end
    end
  end

  assign vga_x      = r_pix.x;
  assign vga_y      = r_pix.y;
  assign vga_plot   = r_pix.valid;
  assign vga_colour = r_src_spr ? r_spr_colour : bg_colour;
  assign spr_gnt    = r_gnt;
  assign busy       = r_busy;
  assign frame_done = r_done;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Self-checking bench for frame_draw_scheduler: timestamped expected-plot
// model built from the scan/sprite rules, checked every cycle.
module tb_frame_draw_scheduler;
  import frame_draw_scheduler_pkg::*;

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic [8:0]  bg_x;
  logic [8:0]  bg_y;
  logic [2:0]  bg_colour;
  logic        spr_req;
  logic [8:0]  spr_x;
  logic [8:0]  spr_y;
  logic [2:0]  spr_colour;
  logic        spr_last;
  logic        spr_gnt;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        frame_done;

  frame_draw_scheduler dut (
    .clock(clock), .resetn(resetn), .start(start),
    .bg_x(bg_x), .bg_y(bg_y), .bg_colour(bg_colour),
    .spr_req(spr_req), .spr_x(spr_x), .spr_y(spr_y), .spr_colour(spr_colour),
    .spr_last(spr_last), .spr_gnt(spr_gnt),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Background picture: grass strip, helicopter box, white block, black sky
  function automatic logic [2:0] bg_fn(input int x, input int y);
    if (y >= 200) return GRASS;
    if (x >= 200 && x < 300 && y < 80) return HELI;
    if (x < 100 && y >= 150) return WHITE;
    return BLACK;
  endfunction

  always @(posedge clock) bg_colour <= bg_fn(int'(bg_x), int'(bg_y));

  typedef struct { int cyc; int x; int y; int col; } ev_t;
  typedef struct { int x; int y; int col; } px_t;

  ev_t pq[$];
  int  fdq[$];
  px_t bq[$];
  int  fd_log[$];

  int  n_cmp = 0;
  int  n_fail = 0;
  bit  chk_en = 0;
  int  plot_cnt = 0;
  int  first_plot_cyc = -1;
  int  first_gnt_cyc = -1;
  int  last_acc_cyc = -1;
  int  last_frame_base = 0;
  int  cap_w = -1, cap_g = -1, cap_h = -1, cap_b = -1;
  ev_t h_ev;
  bit  exp_plot;
  bit  exp_fd;

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // A frame whose scan start is sampled at the edge after cycle n
  task automatic push_frame(input int n);
    for (int k = 0; k < int'(H_RES * V_RES); k++) begin
      pq.push_back('{n + 2 + k, k % int'(H_RES), k / int'(H_RES),
                     int'(bg_fn(k % int'(H_RES), k / int'(H_RES)))});
    end
    fdq.push_back(n + int'(H_RES * V_RES) + 2);
    last_frame_base = n;
  endtask

  // Per-cycle compare of plot and frame_done against the timestamped model
  always @(negedge clock) begin
    if (chk_en) begin
      while (pq.size() > 0 && pq[0].cyc < cyc) begin
        n_cmp++; n_fail++;
        $display("FAIL missed_plot: expected plot (%0d,%0d) at cycle %0d never seen",
                 pq[0].x, pq[0].y, pq[0].cyc);
        void'(pq.pop_front());
      end
      exp_plot = (pq.size() > 0 && pq[0].cyc == cyc);
      n_cmp++;
      if (exp_plot) begin
        h_ev = pq.pop_front();
        if (vga_plot !== 1'b1 || int'(vga_x) != h_ev.x || int'(vga_y) != h_ev.y ||
            int'(vga_colour) != h_ev.col) begin
          n_fail++;
          $display("FAIL plot cyc %0d: got plot=%b (%0d,%0d) c=%0d expected plot=1 (%0d,%0d) c=%0d",
                   cyc, vga_plot, vga_x, vga_y, vga_colour, h_ev.x, h_ev.y, h_ev.col);
        end
      end else if (vga_plot !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_plot cyc %0d: got plot=%b (%0d,%0d) expected plot=0",
                 cyc, vga_plot, vga_x, vga_y);
      end
      while (fdq.size() > 0 && fdq[0] < cyc) void'(fdq.pop_front());
      exp_fd = (fdq.size() > 0 && fdq[0] == cyc);
      if (exp_fd) void'(fdq.pop_front());
      n_cmp++;
      if (frame_done !== exp_fd) begin
        n_fail++;
        $display("FAIL frame_done cyc %0d: got %b expected %b", cyc, frame_done, exp_fd);
      end
      if (vga_plot === 1'b1) begin
        plot_cnt++;
        if (first_plot_cyc < 0) first_plot_cyc = cyc;
        if (vga_x == 9'd60  && vga_y == 8'd180) cap_w = int'(vga_colour);
        if (vga_x == 9'd0   && vga_y == 8'd237) cap_g = int'(vga_colour);
        if (vga_x == 9'd245 && vga_y == 8'd35)  cap_h = int'(vga_colour);
        if (vga_x == 9'd150 && vga_y == 8'd150) cap_b = int'(vga_colour);
      end
      if (frame_done === 1'b1) fd_log.push_back(cyc);
    end
  end

  // Drives bq as one sprite burst; optional 10-cycle hold with a start pulse
  task automatic run_burst(input bit gaps, input int hold_at, input bit defer_start);
    int  n;
    bit  g;
    int  e;
    int  waited;
    n = bq.size();
    for (int i = 0; i < n; i++) begin
      if (i == hold_at) begin
        spr_req = 1'b0; spr_last = 1'b0;
        for (int h = 0; h < 10; h++) begin
          start = defer_start && (h == 3);
          check("gnt_hold", int'(spr_gnt), 1);
          tick();
        end
        start = 1'b0;
      end else if (gaps && i > 0) begin
        spr_req = 1'b0; spr_last = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      spr_x      = 9'(bq[i].x);
      spr_y      = 9'(bq[i].y);
      spr_colour = 3'(bq[i].col);
      spr_last   = (i == n - 1);
      spr_req    = 1'b1;
      waited = 0;
      forever begin
        g = spr_gnt;
        e = cyc;
        if (g && first_gnt_cyc < 0) first_gnt_cyc = e;
        tick();
        if (g) break;
        waited++;
        if (waited > 200000) begin
          check("gnt_timeout", 0, 1);
          finish_run();
        end
      end
      if (bq[i].x < int'(H_RES) && bq[i].y < int'(V_RES))
        pq.push_back('{e + 1, bq[i].x, bq[i].y, bq[i].col});
      last_acc_cyc = e + 1;
      if (i == n - 1 && defer_start) push_frame(e);
    end
    spr_req = 1'b0; spr_last = 1'b0;
    bq.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bg_x"}, int'(bg_x), 0);
    check({tag, "_bg_y"}, int'(bg_y), 0);
    check({tag, "_vga_x"}, int'(vga_x), 0);
    check({tag, "_vga_y"}, int'(vga_y), 0);
    check({tag, "_plot"}, int'(vga_plot), 0);
    check({tag, "_gnt"}, int'(spr_gnt), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(frame_done), 0);
  endtask

  int base;
  int n0;
  int m;

  initial begin
    resetn = 1'b0; start = 1'b0; spr_req = 1'b0; spr_last = 1'b0;
    spr_x = '0; spr_y = '0; spr_colour = '0;
    repeat (3) tick();
    check_all_zero("reset");
    chk_en = 1'b1;
    resetn = 1'b1;
    repeat (2) tick();

    // Off-screen sprite pixels are accepted but not plotted
    bq.push_back('{330, 10, 5});
    bq.push_back('{10, 250, 3});
    bq.push_back('{5, 5, 6});
    base = plot_cnt;
    run_burst(1'b1, -1, 1'b0);
    check("range_gnt_after_last", int'(spr_gnt), 0);
    check("range_busy_after_last", int'(busy), 0);
    tick();
    check("range_plot_count", plot_cnt - base, 1);

    // Random sprite bursts with random gaps and off-screen pixels
    for (int b = 0; b < 6; b++) begin
      repeat ($urandom_range(0, 5)) tick();
      for (int p = 0; p < int'($urandom_range(1, 6)); p++)
        bq.push_back('{int'($urandom_range(0, 340)), int'($urandom_range(0, 260)),
                       int'($urandom_range(0, 7))});
      run_burst(1'b1, -1, 1'b0);
    end
    repeat (3) tick();

    // Mid-burst hold with a deferred start, then reset at scan pixel (100,50)
    for (int p = 0; p < 3; p++)
      bq.push_back('{int'($urandom_range(0, 319)), int'($urandom_range(0, 239)),
                     int'($urandom_range(0, 7))});
    run_burst(1'b0, 1, 1'b1);
    check("defer_busy", int'(busy), 1);
    while (cyc < last_frame_base + 1 + 50 * int'(H_RES) + 100) tick();
    check("scan_x_at_reset", int'(bg_x), 100);
    check("scan_y_at_reset", int'(bg_y), 50);
    resetn = 1'b0;
    m = cyc + 1;
    while (pq.size() > 0 && pq[$].cyc >= m) void'(pq.pop_back());
    while (fdq.size() > 0 && fdq[$] >= m) void'(fdq.pop_back());
    tick();
    resetn = 1'b1;
    check_all_zero("midscan_reset");
    repeat (100) tick();
    check("post_reset_busy", int'(busy), 0);

    // start + spr_req together, second start at +1000, third at +5000
    for (int p = 0; p < 4; p++)
      bq.push_back('{int'($urandom_range(0, 319)), int'($urandom_range(0, 239)),
                     int'($urandom_range(0, 7))});
    n0 = cyc;
    base = plot_cnt;
    first_plot_cyc = -1;
    first_gnt_cyc = -1;
    fd_log.delete();
    cap_w = -1; cap_g = -1; cap_h = -1; cap_b = -1;
    fork
      run_burst(1'b0, -1, 1'b0);
      begin
        start = 1'b1;
        push_frame(n0);
        push_frame(n0 + int'(H_RES * V_RES) + 1);
        tick();
        start = 1'b0;
        while (cyc < n0 + 1000) tick();
        check("busy_mid_scan", int'(busy), 1);
        start = 1'b1; tick(); start = 1'b0;
        while (cyc < n0 + 5000) tick();
        start = 1'b1; tick(); start = 1'b0;
      end
    join
    check("gnt_after_last", int'(spr_gnt), 0);
    check("busy_after_last", int'(busy), 0);
    check("first_gnt_cycle", first_gnt_cyc - n0, 153603);
    check("last_sprite_cycle", last_acc_cyc - n0, 153607);
    tick();
    check("first_plot_cycle", first_plot_cyc - n0, 2);
    check("total_plots", plot_cnt - base, 153604);
    check("frame_done_count", fd_log.size(), 2);
    if (fd_log.size() == 2) begin
      check("frame_done_1", fd_log[0] - n0, 76802);
      check("frame_done_2", fd_log[1] - n0, 153603);
    end
    check("colour_60_180", cap_w, 7);
    check("colour_0_237", cap_g, 2);
    check("colour_245_35", cap_h, 6);
    check("colour_150_150", cap_b, 0);

    repeat (50) tick();
    check("model_plots_left", pq.size(), 0);
    check("model_done_left", fdq.size(), 0);
    finish_run();
  end

endmodule
